// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data-memory responder: funct3 codes,
// FSM states and the MMIO cycle-counter address.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [31:0] MMIO_CYCLE_CNT_ADDR = 32'hFFFF_FFF0;

  typedef enum logic {IDLE, SPLIT} memStateT;

  // Byte-lane mask of an access at offset 0; funct3[1:0] encodes the size.
  function automatic logic [3:0] sizeMask(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    sizeMask = 4'b0001;
      2'd1:    sizeMask = 4'b0011;
      default: sizeMask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed bytes out of an 8-byte little-endian window and
// sign/zero-extends them according to funct3.
module load_align_ext
  import mem_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'(window >> {offset, 3'b000});
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    result = shifted;
      F3_BU:   result = {24'b0, shifted[7:0]};
      F3_HU:   result = {16'b0, shifted[15:0]};
      default: result = 32'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data memory: byte-lane stores, extended loads, word-straddling
// accesses split over two cycles. MMIO_CYCLE_CNT_EN maps a cycle counter.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] Mem_WrAddr,
  input  logic [31:0]       Mem_WrData,
  output logic [31:0]       ReadDataM,
  output logic              MemStallM,
  output logic              MemErrM
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  memStateT          state;
  logic [2:0]        holdF3;
  logic [ADDR_W-1:0] holdAddr;
  logic [31:0]       holdData;
  logic [31:0]       holdLo;
  logic              holdWrite;

  logic [31:0] mem [DEPTH_WORDS];

  logic              inSplit;
  logic [2:0]        actF3;
  logic [ADDR_W-1:0] actAddr;
  logic [31:0]       actData;
  logic [1:0]        off;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  accessIdx;
  logic [7:0]        be8;
  logic [63:0]       laneData64;
  logic              straddle;
  logic              doWrite;
  logic              doRead;
  logic              legalF3;
  logic              startSplit;
  logic [31:0]       rdWord;
  logic [63:0]       window;
  logic [31:0]       extData;
  logic              memWe;
  logic [3:0]        laneEn;
  logic [31:0]       laneWData;
  logic              mmioHit;
  logic [31:0]       mmioData;

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cycleCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycleCnt <= 32'b0;
    else       cycleCnt <= cycleCnt + 32'd1;
  end

  assign mmioHit  = (actAddr == ADDR_W'(MMIO_CYCLE_CNT_ADDR));
  assign mmioData = (actF3 == F3_W) ? cycleCnt : 32'b0;
`else
  assign mmioHit  = 1'b0;
  assign mmioData = 32'b0;
`endif

  // In SPLIT everything is taken from the latched copy; the core's held
  // inputs are not trusted.
  always_comb begin
    inSplit    = (state == SPLIT);
    actF3      = inSplit ? holdF3   : funct3M;
    actAddr    = inSplit ? holdAddr : Mem_WrAddr;
    actData    = inSplit ? holdData : Mem_WrData;
    off        = actAddr[1:0];
    idx        = IDX_W'(actAddr >> 2);
    accessIdx  = inSplit ? idx + IDX_W'(1) : idx;
    be8        = {4'b0000, sizeMask(actF3)} << off;
    laneData64 = {32'b0, actData} << {off, 3'b000};
    straddle   = |be8[7:4];
    doWrite    = MemWriteM;
    doRead     = MemReadM && !MemWriteM;
    legalF3    = doWrite ? (funct3M inside {F3_B, F3_H, F3_W})
                         : (funct3M inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    startSplit = !reset && !inSplit && (doWrite || doRead) && legalF3
                 && !mmioHit && straddle;
    rdWord     = mem[accessIdx];
    window     = inSplit ? {rdWord, holdLo} : {32'b0, rdWord};
  end

  load_align_ext u_align (
    .window (window),
    .offset (off),
    .funct3 (actF3),
    .result (extData)
  );

  always_comb begin
    ReadDataM = 32'b0;
    MemStallM = 1'b0;
    MemErrM   = 1'b0;
    memWe     = 1'b0;
    laneEn    = 4'b0;
    laneWData = 32'b0;
    if (!reset) begin
      if (inSplit) begin
        if (holdWrite) begin
          memWe     = 1'b1;
          laneEn    = be8[7:4];
          laneWData = laneData64[63:32];
        end else begin
          ReadDataM = extData;
        end
      end else if (doWrite || doRead) begin
        if (!legalF3) begin
          MemErrM = 1'b1;
        end else if (mmioHit) begin
          ReadDataM = doRead ? mmioData : 32'b0;
        end else begin
          if (doWrite) begin
            memWe     = 1'b1;
            laneEn    = be8[3:0];
            laneWData = laneData64[31:0];
          end
          if (straddle)    MemStallM = 1'b1;
          else if (doRead) ReadDataM = extData;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (memWe && laneEn[b]) mem[accessIdx][8*b +: 8] <= laneWData[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      holdF3    <= 3'b0;
      holdAddr  <= '0;
      holdData  <= 32'b0;
      holdLo    <= 32'b0;
      holdWrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startSplit) begin
            state     <= SPLIT;
            holdF3    <= funct3M;
            holdAddr  <= Mem_WrAddr;
            holdData  <= Mem_WrData;
            holdWrite <= doWrite;
            holdLo    <= doWrite ? 32'b0 : rdWord;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
